// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Active-low segment order is {a,b,c,d,e,f,g}, with a in bit 6.
package disp_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low one-hot enable vector for the given digit slot.
    function automatic logic [NUM_DIGITS-1:0] enable_low(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low 7-segment pattern converter.
module seg7_decode
    import disp_pkg::*;
(
    input  digit_t digit_i,
    output seg_t   seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            4'hF: seg_o = 7'b0111000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed display scanner with a two-requester round-robin write port.
// Define DISP_LZ_BLANK_EN to suppress leading zeros on digits 7..1.
//
// state | meaning
// BLANK | all digits and segments off for BLANK_CYCLES at slot start (anti-ghosting)
// DRIVE | enable of digit scan_idx low, segments show that digit until next tick
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [2:0] req0_sel,
    input  logic [3:0] req0_num,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_sel,
    input  logic [3:0] req1_num,
    output logic       req1_ready,
    output logic [7:0] digit_en_n,
    output logic [6:0] segments,
    output logic [2:0] scan_idx
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    logic [PW-1:0] presc_q;
    logic [BW-1:0] blank_q;
    scan_state_t   state_q;
    logic [2:0]    scan_idx_q;
    digit_t        digit_q [NUM_DIGITS];
    logic          last_grant_q;

    logic          tick;
    logic          gnt0;
    logic          gnt1;
    logic          wr_en_d;
    logic [2:0]    wr_sel_d;
    digit_t        wr_num_d;
    digit_t        cur_digit;
    seg_t          dec_seg;
    logic          suppress;

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // A tick always restarts the slot, regardless of where BLANK/DRIVE stand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BLANK;
            blank_q    <= '0;
            scan_idx_q <= '0;
        end else if (tick) begin
            state_q    <= BLANK;
            blank_q    <= '0;
            scan_idx_q <= scan_idx_q + 1'b1;
        end else begin
            case (state_q)
                BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        state_q <= DRIVE;
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                DRIVE: state_q <= DRIVE;
                default: state_q <= BLANK;
            endcase
        end
    end

    // last_grant_q = 1 means requester 1 won the most recent transfer.
    always_comb begin
        gnt0 = ~reset & req0_valid & (~req1_valid | last_grant_q);
        gnt1 = ~reset & req1_valid & (~req0_valid | ~last_grant_q);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        wr_en_d  = gnt0 | gnt1;
        wr_sel_d = gnt0 ? req0_sel : req1_sel;
        wr_num_d = gnt0 ? req0_num : req1_num;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (gnt0) begin
            last_grant_q <= 1'b0;
        end else if (gnt1) begin
            last_grant_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            digit_q[wr_sel_d] <= wr_num_d;
        end
    end

    assign cur_digit = digit_q[scan_idx_q];

    seg7_decode u_seg7_decode (
        .digit_i (cur_digit),
        .seg_o   (dec_seg)
    );

`ifdef DISP_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  upper_zero;

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero & (digit_q[i] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end

    assign suppress = lz_mask[scan_idx_q];
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        digit_en_n = 8'hFF;
        segments   = SEG_BLANK;
        if (state_q == DRIVE) begin
            digit_en_n = enable_low(scan_idx_q);
            segments   = suppress ? SEG_BLANK : dec_seg;
        end
    end

    assign scan_idx = scan_idx_q;

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000: clock cycles per digit slot.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 4: anti-ghosting blank cycles at the start of each slot; legal range 1 <= BLANK_CYCLES < CLK_DIV.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req0_valid, input, 1 bit: requester 0 write request.
REQ-006 The block SHALL have port req0_sel, input, 3 bits: requester 0 target digit index.
REQ-007 The block SHALL have port req0_num, input, 4 bits: requester 0 hex value.
REQ-008 The block SHALL have port req0_ready, output, 1 bit: requester 0 grant.
REQ-009 The block SHALL have ports req1_valid, req1_sel, req1_num and req1_ready, identical in direction, width and meaning to the requester 0 ports, for requester 1.
REQ-010 The block SHALL have port digit_en_n, output, 8 bits: active-low digit enables; bit i selects digit i.
REQ-011 The block SHALL have port segments, output, 7 bits: active-low segments {a,b,c,d,e,f,g}, with a at bit 6.
REQ-012 The block SHALL have port scan_idx, output, 3 bits: digit slot currently scanned.

Function
REQ-013 The block SHALL hold eight 4-bit digit registers, digit[0..7].
REQ-014 The prescaler SHALL count 0..CLK_DIV-1; the tick SHALL be asserted when the count equals CLK_DIV-1, and the count SHALL then wrap to 0.
REQ-015 On a tick edge, scan_idx SHALL increment modulo 8 (7 wraps to 0), the FSM SHALL enter BLANK, and the blank counter SHALL clear.
REQ-016 The FSM SHALL have states BLANK and DRIVE; BLANK SHALL last exactly BLANK_CYCLES cycles before moving to DRIVE, and DRIVE SHALL last until the next tick.
REQ-017 In BLANK, outputs SHALL be digit_en_n=8'hFF and segments=7'h7F.
REQ-018 In DRIVE, digit_en_n SHALL have only bit scan_idx low, and segments SHALL equal decode(digit[scan_idx]).
REQ-019 The decode SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
REQ-020 digit_en_n and segments SHALL be decoded combinationally from registered state only, never from request inputs.
REQ-021 The arbiter SHALL grant at most one write per cycle; readyX SHALL be combinational and high only for the granted requester, which must also be valid.
REQ-022 A single valid requester SHALL be granted immediately.
REQ-023 When both requesters are valid, the grant SHALL go to the requester not recorded in last_grant; last_grant SHALL update only on a transfer (valid && ready).
REQ-024 On a transfer, digit[sel] <= num at that clock edge; the new value SHALL be visible on segments the following cycle if that digit is being driven.
REQ-025 A write SHALL NOT disturb the prescaler, the FSM or scan_idx.
REQ-026 If both requesters target the same index simultaneously, only the granted requester's data SHALL be written.

Reset
REQ-027 While reset is high, the block SHALL hold: all digit registers 0, prescaler 0, blank counter 0, scan_idx 0, FSM in BLANK, last_grant=1, digit_en_n=8'hFF, segments=7'h7F, req0_ready=0, req1_ready=0.
REQ-028 Reset asserted mid-slot SHALL force the reset values of REQ-027 immediately; after release, operation SHALL restart from slot 0 in BLANK.

Configuration
REQ-029 With macro DISP_LZ_BLANK_EN defined, in DRIVE a digit i>0 SHALL show segments=7'h7F (with its enable still low) when digit[i] and all digit[j], j>i, are 0; digit 0 SHALL always be shown.
REQ-030 With DISP_LZ_BLANK_EN undefined, all digits SHALL display their values, including zeros.

Structure
REQ-031 Package disp_pkg SHALL hold: NUM_DIGITS=8, SEG_BLANK=7'h7F, typedefs digit_t (4 bits) and seg_t (7 bits), and enum scan_state_t {BLANK, DRIVE}.
REQ-032 Sub-module seg7_decode SHALL be a combinational digit_t to seg_t converter implementing REQ-019.

Verification (all scenarios use CLK_DIV=8, BLANK_CYCLES=2)
REQ-033 Release reset, no requests -> digit_en_n=FF for cycles 0-1, FE for cycles 2-7, FF for cycles 8-9, FD from cycle 10; segments=0000001 while driving.
REQ-034 req0 only, sel=3, num=5 for one cycle -> req0_ready=1 in that cycle; segments=0100100 in slot 3 DRIVE.
REQ-035 Both requesters valid for 3 cycles after reset -> grants req0, req1, req0; with both targeting sel=2, digit 2 ends holding req0's final num.
REQ-036 Run 9 ticks -> scan_idx sequence 1..7 then wraps to 0, then 1; no two enable bits ever low together.
REQ-037 Assert reset asynchronously mid-DRIVE with digit 4=A -> digit_en_n=FF and segments=7F before the next edge; after release, slot 4 shows 0000001.
REQ-038 With DISP_LZ_BLANK_EN: digit0=7, others 0 -> only slot 0 lit; then write digit4=1 -> slots 0-4 lit and slots 5-7 show 7F.
